vfp_config_sequencer: RTL and testbench
=======================================

Name: vfp_config_sequencer

Overview:
- AXI4-Lite configuration master that sequences the VFP video pipeline's vfpconfig register bank from a table of (address, data, verify) entries.
- On `start`, it writes every entry in order. Flagged entries are read back and compared.
- Reports busy, done or error status to the system controller; sits between the boot/control logic and the VFP config slave port.

Parameters:
- ADDR_WIDTH, 8, AXI4-Lite address width (matches C_vfpConfig_ADDR_WIDTH).
- DATA_WIDTH, 32, AXI4-Lite data width (matches C_vfpConfig_DATA_WIDTH).
- NUM_ENTRIES, 16, number of table entries per sequence (>=1).
- IDX_WIDTH, $clog2(NUM_ENTRIES) (min 1), table index width.
- TIMEOUT_CYCLES, 255, max cycles waited in any handshake state.

Ports:
- vfpconfig_aclk  in  1  clock, all logic rising-edge.
- vfpconfig_areset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to run the table; ignored while busy.
- tbl_index  out  IDX_WIDTH  table entry being fetched.
- tbl_addr  in  ADDR_WIDTH  entry register address; valid 1 cycle after tbl_index.
- tbl_data  in  DATA_WIDTH  entry write data; same timing as tbl_addr.
- tbl_verify  in  1  1 = read back and compare this entry; same timing.
- m_awaddr/m_awprot/m_awvalid  out  ADDR_WIDTH/3/1; m_awready  in  1.
- m_wdata/m_wstrb/m_wvalid  out  DATA_WIDTH/DATA_WIDTH/8/1; m_wready  in  1.
- m_bresp  in  2; m_bvalid  in  1; m_bready  out  1.
- m_araddr/m_arprot/m_arvalid  out  ADDR_WIDTH/3/1; m_arready  in  1.
- m_rdata  in  DATA_WIDTH; m_rresp  in  2; m_rvalid  in  1; m_rready  out  1.
- busy  out  1  sequence in progress.
- done  out  1  sticky: last sequence completed cleanly; cleared on accepted start.
- error  out  1  sticky: last sequence aborted; cleared on accepted start.
- err_code  out  2  1 = slave error response, 2 = readback mismatch, 3 = timeout.
- err_index  out  IDX_WIDTH  table index of the failing entry.

Behaviour:
- Reset: every output is 0, and the FSM is in IDLE. Reset mid-transaction drops all valids next cycle with no completion.
- Protection and strobes: awprot = arprot = 3'b000; wstrb is all ones; outputs are registered.
- IDLE: on start, set tbl_index = 0, busy = 1, clear done/error/err_code/err_index, then go to FETCH.
- FETCH (1 cycle): register tbl_addr/tbl_data/tbl_verify into the cur_* registers, then go to WRITE.
- WRITE: m_awvalid and m_wvalid are asserted together on entry.
  - Each channel deasserts independently the cycle after its own valid&ready.
  - Go to BRESP once both handshakes are done, including when both complete in the same cycle.
  - awaddr and wdata stay stable while their valid is high.
- BRESP: m_bready = 1.
  - On bvalid with bresp != 2'b00: go to ERR with code 1.
  - On bvalid with OKAY: go to READ if cur_verify, otherwise NEXT.
- READ: m_arvalid = 1 with araddr = cur_addr until arready, then go to RRESP.
- RRESP: m_rready = 1.
  - On rvalid with rresp != OKAY: ERR with code 1.
  - On rvalid with rdata != cur_data: ERR with code 2.
  - Otherwise go to NEXT.
- NEXT: if tbl_index == NUM_ENTRIES-1, go to DONE; otherwise increment tbl_index and go to FETCH.
- DONE: set busy = 0 and done = 1, then go to IDLE.
- ERR: set busy = 0, error = 1, err_index = tbl_index, and latch err_code. Drop all valids and readies, then go to IDLE.
- Timeout:
  - A wait counter clears on entry to WRITE/BRESP/READ/RRESP and increments each cycle in that state.
  - Reaching TIMEOUT_CYCLES goes to ERR with code 3.
  - The handshake is abandoned; a subsequent stray bvalid/rvalid in IDLE is ignored (readies are 0).
- start while busy: ignored. start in the same cycle DONE/ERR returns to IDLE: ignored; it is accepted only in IDLE.
- Latency: minimum per unverified entry is 1 FETCH + 1 WRITE + 1 BRESP + 1 NEXT = 4 cycles with zero-wait slave. Verified entries add 2.

Decomposition:
- Shared package vfp_cfg_pkg holds:
  - the state enum (IDLE, FETCH, WRITE, BRESP, READ, RRESP, NEXT, DONE, ERR);
  - error-code constants ERR_SLV = 2'd1, ERR_MISMATCH = 2'd2, ERR_TIMEOUT = 2'd3;
  - the AXI_OKAY = 2'b00 response constant.
- One sub-module is natural: vfp_cfg_watchdog, the clear/enable/expire counter of width $clog2(TIMEOUT_CYCLES+1).

Test Plan:
- 3-entry table {0x04:0x1, 0x08:0xAB, 0x0C:0x55 verify=1}, zero-wait slave -> 3 AW/W writes in order, 1 AR at 0x0C. done=1 after 4+4+6 cycles plus the DONE cycle; error=0.
- Slave holds awready low 5 cycles while wready is immediate -> wvalid drops after 1 cycle, awvalid is held with awaddr stable, and BRESP is entered only after the AW handshake.
- Entry 1 bresp=2'b10 (SLVERR) -> error=1, err_code=1, err_index=1; entries 2+ never written; busy falls.
- Verify entry returns rdata 0x54 for expected 0x55 -> err_code=2, err_index=2, done=0.
- Slave never asserts bvalid, TIMEOUT_CYCLES=255 -> ERR after 255 cycles in BRESP, err_code=3. A late bvalid is ignored; a new start succeeds.
- start pulsed mid-sequence, and reset asserted mid-WRITE -> the start is ignored and the sequence continues; after reset all outputs are 0 and valids drop next cycle.

Source files
------------

// File: rtl/vfp_cfg_pkg.sv
// vfp_cfg_pkg: shared state, error-code and AXI response definitions for the vfpconfig sequencer
package vfp_cfg_pkg;
  typedef enum logic [3:0] {IDLE, FETCH, WRITE, BRESP, READ, RRESP, NEXT, DONE, ERR} state_t;
  localparam logic [1:0] ERR_SLV      = 2'd1;
  localparam logic [1:0] ERR_MISMATCH = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;
  localparam logic [1:0] AXI_OKAY     = 2'b00;
  function automatic logic is_wait_state(state_t s);
    return s inside {WRITE, BRESP, READ, RRESP};
  endfunction
endpackage

// File: rtl/vfp_cfg_watchdog.sv
// vfp_cfg_watchdog: handshake wait counter that flags expiry on the LIMIT-th enabled cycle
module vfp_cfg_watchdog #(
  parameter int LIMIT = 255,
  parameter int W     = $clog2(LIMIT + 1)
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge i_clk)
    if (i_rst || i_clr) r_cnt <= '0;
    else if (i_en && !o_expired) r_cnt <= r_cnt + 1'b1;
  assign o_expired = i_en && (r_cnt == W'(LIMIT - 1));
endmodule

// File: rtl/vfp_config_sequencer.sv
// vfp_config_sequencer: AXI4-Lite master that writes (and optionally verifies) a register table
module vfp_config_sequencer
  import vfp_cfg_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_ENTRIES    = 16,
  parameter int IDX_WIDTH      = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    vfpconfig_aclk,
  input  logic                    vfpconfig_areset,
  input  logic                    start,
  output logic [IDX_WIDTH-1:0]    tbl_index,
  input  logic [ADDR_WIDTH-1:0]   tbl_addr,
  input  logic [DATA_WIDTH-1:0]   tbl_data,
  input  logic                    tbl_verify,
  output logic [ADDR_WIDTH-1:0]   m_awaddr,
  output logic [2:0]              m_awprot,
  output logic                    m_awvalid,
  input  logic                    m_awready,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wstrb,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  input  logic [1:0]              m_bresp,
  input  logic                    m_bvalid,
  output logic                    m_bready,
  output logic [ADDR_WIDTH-1:0]   m_araddr,
  output logic [2:0]              m_arprot,
  output logic                    m_arvalid,
  input  logic                    m_arready,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  input  logic [1:0]              m_rresp,
  input  logic                    m_rvalid,
  output logic                    m_rready,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [1:0]              err_code,
  output logic [IDX_WIDTH-1:0]    err_index
);
  state_t                r_state, w_next;
  logic [1:0]            w_code, r_err_pend, r_err_code;
  logic [IDX_WIDTH-1:0]  r_idx, r_err_index;
  logic [ADDR_WIDTH-1:0] r_cur_addr;
  logic [DATA_WIDTH-1:0] r_cur_data;
  logic                  r_cur_verify;
  logic                  r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
  logic                  r_busy, r_done, r_error;
  logic                  w_last, w_wr_done, w_accept, w_wd_clr, w_wd_en, w_expired;

  assign w_last    = r_idx == IDX_WIDTH'(NUM_ENTRIES - 1);
  assign w_wr_done = (!r_awvalid || m_awready) && (!r_wvalid || m_wready);
  assign w_accept  = (r_state == IDLE) && start;
  assign w_wd_en   = is_wait_state(r_state);
  assign w_wd_clr  = is_wait_state(w_next) && (w_next != r_state);

  vfp_cfg_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
    .i_clk    (vfpconfig_aclk),
    .i_rst    (vfpconfig_areset),
    .i_clr    (w_wd_clr),
    .i_en     (w_wd_en),
    .o_expired(w_expired)
  );

  always_ff @(posedge vfpconfig_aclk)
    r_state <= vfpconfig_areset ? IDLE : w_next;

  // Completed handshakes take priority over a coincident timeout
  always_comb begin
    w_next = r_state;
    w_code = ERR_TIMEOUT;
    unique case (r_state)
      IDLE:  w_next = start ? FETCH : IDLE;
      FETCH: w_next = WRITE;
      WRITE: w_next = w_wr_done ? BRESP : w_expired ? ERR : WRITE;
      BRESP: if (m_bvalid) begin
        w_code = ERR_SLV;
        w_next = (m_bresp != AXI_OKAY) ? ERR : r_cur_verify ? READ : NEXT;
      end else if (w_expired) w_next = ERR;
      READ:  w_next = m_arready ? RRESP : w_expired ? ERR : READ;
      RRESP: if (m_rvalid) begin
        w_code = (m_rresp != AXI_OKAY) ? ERR_SLV : ERR_MISMATCH;
        w_next = (m_rresp != AXI_OKAY || m_rdata != r_cur_data) ? ERR : NEXT;
      end else if (w_expired) w_next = ERR;
      NEXT:  w_next = w_last ? DONE : FETCH;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge vfpconfig_aclk) begin
    if (vfpconfig_areset) begin
      {r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready} <= '0;
      {r_busy, r_done, r_error, r_cur_verify}              <= '0;
      r_idx       <= '0;
      r_cur_addr  <= '0;
      r_cur_data  <= '0;
      r_err_pend  <= '0;
      r_err_code  <= '0;
      r_err_index <= '0;
    end else begin
      r_awvalid <= (w_next == WRITE) && (r_state != WRITE || (r_awvalid && !m_awready));
      r_wvalid  <= (w_next == WRITE) && (r_state != WRITE || (r_wvalid && !m_wready));
      r_bready  <= w_next == BRESP;
      r_arvalid <= w_next == READ;
      r_rready  <= w_next == RRESP;
      r_busy    <= w_next != IDLE;
      if (w_accept) r_idx <= '0;
      else if (r_state == NEXT && !w_last) r_idx <= r_idx + 1'b1;
      if (r_state == FETCH) begin
        r_cur_addr   <= tbl_addr;
        r_cur_data   <= tbl_data;
        r_cur_verify <= tbl_verify;
      end
      if (w_next == ERR) r_err_pend <= w_code;
      if (w_accept) begin
        {r_done, r_error} <= '0;
        r_err_code  <= '0;
        r_err_index <= '0;
      end else if (r_state == DONE) r_done <= 1'b1;
      else if (r_state == ERR) begin
        r_error     <= 1'b1;
        r_err_code  <= r_err_pend;
        r_err_index <= r_idx;
      end
    end
  end

  assign tbl_index = r_idx;
  assign m_awaddr  = r_cur_addr;
  assign m_awprot  = 3'b000;
  assign m_awvalid = r_awvalid;
  assign m_wdata   = r_cur_data;
  assign m_wstrb   = '1;
  assign m_wvalid  = r_wvalid;
  assign m_bready  = r_bready;
  assign m_araddr  = r_cur_addr;
  assign m_arprot  = 3'b000;
  assign m_arvalid = r_arvalid;
  assign m_rready  = r_rready;
  assign busy      = r_busy;
  assign done      = r_done;
  assign error     = r_error;
  assign err_code  = r_err_code;
  assign err_index = r_err_index;
endmodule

// File: tb/tb_vfp_config_sequencer.sv
// tb_vfp_config_sequencer: directed checks of the sequencer against a small AXI4-Lite slave model
`timescale 1ns/1ps
module tb_vfp_config_sequencer;
  localparam int AW = 8, DW = 32, NE = 3, IW = 2, TO = 255;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [IW-1:0] tbl_index, err_index;
  logic [AW-1:0] tbl_addr, m_awaddr, m_araddr;
  logic [DW-1:0] tbl_data, m_wdata, m_rdata;
  logic [DW/8-1:0] m_wstrb;
  logic [2:0] m_awprot, m_arprot;
  logic [1:0] m_bresp, m_rresp, err_code;
  logic tbl_verify, m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic m_arvalid, m_arready, m_rvalid, m_rready, busy, done, error;

  logic [AW-1:0] t_addr [4];
  logic [DW-1:0] t_data [4];
  logic          t_ver  [4];
  assign tbl_addr   = t_addr[tbl_index];
  assign tbl_data   = t_data[tbl_index];
  assign tbl_verify = t_ver[tbl_index];

  int aw_hold = 0;
  logic never_b = 1'b0, late_b = 1'b0, berr_on = 1'b0;
  logic [AW-1:0] berr_addr = '0;
  logic [DW-1:0] rflip = '0;
  logic [AW-1:0] aw_log [$], ar_log [$];
  logic [DW-1:0] w_log [$];
  int bad_attr = 0;
  int errors = 0, checks = 0;

  vfp_config_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_ENTRIES(NE), .TIMEOUT_CYCLES(TO)) dut (
    .vfpconfig_aclk(clk), .vfpconfig_areset(rst), .start(start),
    .tbl_index(tbl_index), .tbl_addr(tbl_addr), .tbl_data(tbl_data), .tbl_verify(tbl_verify),
    .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .busy(busy), .done(done), .error(error), .err_code(err_code), .err_index(err_index)
  );

  always #5 clk = ~clk;

  // Slave acts on the falling edge; p_* remember which handshakes the next rising edge completes
  logic p_aw, p_w, p_b, p_ar, p_r, aw_seen, w_seen, b_pend, r_pend;
  logic [AW-1:0] s_awaddr, s_araddr, wa;
  logic [DW-1:0] s_wdata, wd;
  logic [DW-1:0] mem [256];
  int aw_cnt;
  always @(negedge clk) begin
    if (rst) begin
      {p_aw, p_w, p_b, p_ar, p_r, aw_seen, w_seen, b_pend, r_pend} = '0;
      aw_cnt = 0;
      {m_awready, m_wready, m_bvalid, m_arready, m_rvalid} = '0;
      m_bresp = '0; m_rresp = '0; m_rdata = '0;
    end else begin
      if (p_aw) begin aw_seen = 1'b1; wa = s_awaddr; aw_log.push_back(s_awaddr); end
      if (p_w) begin w_seen = 1'b1; wd = s_wdata; w_log.push_back(s_wdata); end
      if (p_b) b_pend = 1'b0;
      if (p_r) r_pend = 1'b0;
      if (aw_seen && w_seen) begin
        aw_seen = 1'b0; w_seen = 1'b0; mem[wa] = wd;
        b_pend  = !never_b;
        m_bresp = (berr_on && wa == berr_addr) ? 2'b10 : 2'b00;
      end
      if (p_ar) begin ar_log.push_back(s_araddr); r_pend = 1'b1; m_rdata = mem[s_araddr] ^ rflip; m_rresp = 2'b00; end
      if (m_awvalid) begin m_awready = (aw_cnt >= aw_hold); aw_cnt++; end
      else begin m_awready = 1'b0; aw_cnt = 0; end
      m_wready  = m_wvalid;
      m_arready = m_arvalid;
      m_bvalid  = b_pend || late_b;
      m_rvalid  = r_pend;
      if ((m_awvalid && m_awprot != 3'b0) || (m_wvalid && m_wstrb != 4'hF) || (m_arvalid && m_arprot != 3'b0)) bad_attr++;
      p_aw = m_awvalid && m_awready; p_w = m_wvalid && m_wready; p_b = m_bvalid && m_bready;
      p_ar = m_arvalid && m_arready; p_r = m_rvalid && m_rready;
      s_awaddr = m_awaddr; s_wdata = m_wdata; s_araddr = m_araddr;
    end
  end

  task automatic load(input logic v2);
    t_addr[0] = 8'h04; t_data[0] = 32'h1;  t_ver[0] = 1'b0;
    t_addr[1] = 8'h08; t_data[1] = 32'hAB; t_ver[1] = 1'b0;
    t_addr[2] = 8'h0C; t_data[2] = 32'h55; t_ver[2] = v2;
    t_addr[3] = 8'h00; t_data[3] = 32'h0;  t_ver[3] = 1'b0;
  endtask

  task automatic kick();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_idle(output int cyc, output int nb);
    cyc = 0; nb = 0;
    while (busy && cyc < 2000) begin
      @(negedge clk); cyc++;
      if (m_bready) nb++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; repeat (3) @(negedge clk);
    if ({busy, done, error, err_code, err_index, tbl_index, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready} !== '0) begin
      errors++; $display("FAIL reset_status: got %h expected 0", {busy, done, error, err_code, err_index, tbl_index, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready});
    end
    checks++;
    if ({m_awaddr, m_wdata, m_araddr, m_awprot, m_arprot} !== '0) begin
      errors++; $display("FAIL reset_bus: got %h expected 0", {m_awaddr, m_wdata, m_araddr, m_awprot, m_arprot});
    end
    checks++;
    rst = 1'b0; @(negedge clk);
  endtask

  task automatic test_basic();
    logic [AW-1:0] exp_a [3] = '{8'h04, 8'h08, 8'h0C};
    logic [DW-1:0] exp_d [3] = '{32'h1, 32'hAB, 32'h55};
    int ba, bw, br, cyc, nb;
    load(1'b1); ba = aw_log.size(); bw = w_log.size(); br = ar_log.size();
    kick(); wait_idle(cyc, nb);
    if (cyc !== 15) begin errors++; $display("FAIL basic_cycles: got %0d expected 15", cyc); end
    checks++;
    if ({busy, done, error} !== 3'b010) begin errors++; $display("FAIL basic_status: got %b expected 010", {busy, done, error}); end
    checks++;
    if (aw_log.size() - ba !== 3) begin errors++; $display("FAIL basic_nwrites: got %0d expected 3", aw_log.size() - ba); end
    checks++;
    for (int i = 0; i < 3; i++) begin
      if (aw_log[ba+i] !== exp_a[i] || w_log[bw+i] !== exp_d[i]) begin
        errors++; $display("FAIL basic_write%0d: got %h:%h expected %h:%h", i, aw_log[ba+i], w_log[bw+i], exp_a[i], exp_d[i]);
      end
      checks++;
    end
    if (ar_log.size() - br !== 1 || ar_log[br] !== 8'h0C) begin
      errors++; $display("FAIL basic_read: got n=%0d addr=%h expected n=1 addr=0c", ar_log.size() - br, ar_log[br]);
    end
    checks++;
    if (bad_attr !== 0) begin errors++; $display("FAIL basic_prot_strb: got %0d bad beats expected 0", bad_attr); end
    checks++;
  endtask

  task automatic test_aw_stall();
    int n_aw, n_w, n_b, bad_addr, early_b, cyc, nb;
    load(1'b0); aw_hold = 5; n_aw = 0; n_w = 0; n_b = 0; bad_addr = 0; early_b = 0;
    kick();
    for (int i = 0; i < 9; i++) begin
      if (m_awvalid) begin n_aw++; if (m_awaddr !== 8'h04) bad_addr++; end
      if (m_wvalid) n_w++;
      if (m_bready) n_b++;
      if (m_bready && m_awvalid) early_b++;
      @(negedge clk);
    end
    if (n_aw !== 6 || n_w !== 1) begin errors++; $display("FAIL stall_valid_cycles: got aw=%0d w=%0d expected aw=6 w=1", n_aw, n_w); end
    checks++;
    if (bad_addr !== 0) begin errors++; $display("FAIL stall_awaddr_stable: got %0d unstable expected 0", bad_addr); end
    checks++;
    if (n_b !== 1 || early_b !== 0) begin errors++; $display("FAIL stall_bresp_order: got b=%0d early=%0d expected b=1 early=0", n_b, early_b); end
    checks++;
    wait_idle(cyc, nb); aw_hold = 0;
    if ({busy, done, error} !== 3'b010) begin errors++; $display("FAIL stall_status: got %b expected 010", {busy, done, error}); end
    checks++;
  endtask

  task automatic test_slverr();
    int ba, cyc, nb;
    load(1'b0); berr_on = 1'b1; berr_addr = 8'h08; ba = aw_log.size();
    kick(); wait_idle(cyc, nb); berr_on = 1'b0;
    if ({busy, done, error} !== 3'b001) begin errors++; $display("FAIL slverr_status: got %b expected 001", {busy, done, error}); end
    checks++;
    if (err_code !== 2'd1 || err_index !== 2'd1) begin errors++; $display("FAIL slverr_code: got %0d/%0d expected 1/1", err_code, err_index); end
    checks++;
    if (aw_log.size() - ba !== 2) begin errors++; $display("FAIL slverr_nwrites: got %0d expected 2", aw_log.size() - ba); end
    checks++;
  endtask

  task automatic test_mismatch();
    int br, cyc, nb;
    load(1'b1); rflip = 32'h1; br = ar_log.size();
    kick(); wait_idle(cyc, nb); rflip = '0;
    if ({busy, done, error} !== 3'b001) begin errors++; $display("FAIL mismatch_status: got %b expected 001", {busy, done, error}); end
    checks++;
    if (err_code !== 2'd2 || err_index !== 2'd2) begin errors++; $display("FAIL mismatch_code: got %0d/%0d expected 2/2", err_code, err_index); end
    checks++;
    if (ar_log.size() - br !== 1) begin errors++; $display("FAIL mismatch_nreads: got %0d expected 1", ar_log.size() - br); end
    checks++;
  endtask

  task automatic test_timeout();
    int cyc, nb, stray;
    load(1'b0); never_b = 1'b1;
    kick(); wait_idle(cyc, nb); never_b = 1'b0;
    if (nb !== TO || cyc !== TO + 3) begin errors++; $display("FAIL timeout_cycles: got bresp=%0d total=%0d expected %0d/%0d", nb, cyc, TO, TO + 3); end
    checks++;
    if ({busy, done, error, err_code, err_index} !== 7'b001_11_00) begin
      errors++; $display("FAIL timeout_status: got %b expected 0011100", {busy, done, error, err_code, err_index});
    end
    checks++;
    late_b = 1'b1; stray = 0;
    repeat (4) begin @(negedge clk); if (busy || m_bready || !error) stray++; end
    late_b = 1'b0; @(negedge clk);
    if (stray !== 0) begin errors++; $display("FAIL timeout_late_bvalid: got %0d disturbed cycles expected 0", stray); end
    checks++;
    kick(); wait_idle(cyc, nb);
    if ({busy, done, error, err_code} !== 5'b010_00) begin errors++; $display("FAIL timeout_restart: got %b expected 01000", {busy, done, error, err_code}); end
    checks++;
  endtask

  task automatic test_start_ignored();
    int ba;
    load(1'b1); ba = aw_log.size();
    kick();
    repeat (3) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (10) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    if ({busy, done} !== 2'b01) begin errors++; $display("FAIL ignore_done_timing: got %b expected 01", {busy, done}); end
    checks++;
    repeat (2) @(negedge clk);
    if (busy !== 1'b0 || aw_log.size() - ba !== 3) begin
      errors++; $display("FAIL ignore_restart: got busy=%b writes=%0d expected busy=0 writes=3", busy, aw_log.size() - ba);
    end
    checks++;
  endtask

  task automatic test_reset_mid();
    int n;
    load(1'b0); aw_hold = 10; n = 0;
    kick();
    while (!m_awvalid && n < 10) begin @(negedge clk); n++; end
    if (m_awvalid !== 1'b1) begin errors++; $display("FAIL rstmid_write_entered: got %b expected 1", m_awvalid); end
    checks++;
    @(negedge clk); rst = 1'b1; @(negedge clk);
    if ({busy, done, error, tbl_index, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, m_awaddr, m_wdata} !== '0) begin
      errors++; $display("FAIL rstmid_outputs: got %h expected 0", {busy, done, error, tbl_index, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, m_awaddr, m_wdata});
    end
    checks++;
    rst = 1'b0; aw_hold = 0; repeat (3) @(negedge clk);
    if ({busy, done, m_awvalid} !== 3'b000) begin errors++; $display("FAIL rstmid_quiet: got %b expected 000", {busy, done, m_awvalid}); end
    checks++;
  endtask

  initial begin
    load(1'b0);
    test_reset();
    test_basic();
    test_aw_stall();
    test_slverr();
    test_mismatch();
    test_timeout();
    test_start_ignored();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation exceeded 1ms");
    $fatal(1);
  end
endmodule
